// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux
// Brief    : Multiplexed N-digit seven-segment driver with hex decode,
//            per-digit decimal points, leading-zero suppression, blink,
//            anti-ghost blanking and frame-synchronous double buffering.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_mux #(
    parameter int NUM_DIG      = 4,
    parameter int DIV          = 500,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 250,
    parameter int DIG_ACT_LOW  = 1,
    parameter int SEG_ACT_LOW  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NUM_DIG-1:0]   digits,
    input  logic [NUM_DIG-1:0]     dp,
    input  logic                   load,
    input  logic                   blank_lz,
    input  logic [NUM_DIG-1:0]     blink_mask,
    output logic [NUM_DIG-1:0]     dig,
    output logic [7:0]             smg,
    output logic                   frame_done
);

    localparam int c_PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_SEL_W = $clog2(NUM_DIG);
    localparam int c_BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_PS_W-1:0]  c_PS_LAST  = c_PS_W'(DIV - 1);
    localparam logic [c_SEL_W-1:0] c_SEL_LAST = c_SEL_W'(NUM_DIG - 1);
    localparam logic [c_BC_W-1:0]  c_BC_LAST  = c_BC_W'(BLINK_FRAMES - 1);
    localparam logic [31:0]        c_BLANK    = BLANK_CYCLES;
    localparam logic               c_DIG_INV  = (DIG_ACT_LOW != 0);
    localparam logic               c_SEG_INV  = (SEG_ACT_LOW != 0);

    // Scan state
    logic [c_PS_W-1:0]    r_prescaler;
    logic [c_SEL_W-1:0]   r_sel;

    // Double buffer: staging is written by load, display is what gets scanned
    logic [4*NUM_DIG-1:0] r_stg_digits;
    logic [NUM_DIG-1:0]   r_stg_dp;
    logic [4*NUM_DIG-1:0] r_disp_digits;
    logic [NUM_DIG-1:0]   r_disp_dp;
    logic                 r_pending;

    // Blink timing
    logic [c_BC_W-1:0]    r_blink_cnt;
    logic                 r_blink_phase;

    // Output registers (physical polarity)
    logic [NUM_DIG-1:0]   r_dig;
    logic [7:0]           r_smg;

    // Combinational scan/decode signals (logical, active-high)
    logic                 w_tick;
    logic                 w_frame;
    logic                 w_ghost;
    logic [3:0]           w_nibble;
    logic                 w_dp_bit;
    logic                 w_lz_hit;
    logic                 w_blink_hit;
    logic                 w_zero_above;
    logic [NUM_DIG-1:0]   w_lz_vec;
    logic [NUM_DIG-1:0]   w_sel_onehot;
    logic [6:0]           w_seg_code;
    logic [7:0]           w_seg_on;
    logic [NUM_DIG-1:0]   w_dig_on;

    assign w_tick     = (r_prescaler == c_PS_LAST);
    assign w_frame    = w_tick && (r_sel == c_SEL_LAST);
    assign w_ghost    = (32'(r_prescaler) < c_BLANK);
    assign frame_done = w_frame;
    assign dig        = r_dig;
    assign smg        = r_smg;

    // Slot prescaler and digit selector with explicit wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescaler <= '0;
            r_sel       <= '0;
        end else begin
            if (w_tick) begin
                r_prescaler <= '0;
                r_sel       <= (r_sel == c_SEL_LAST) ? '0 : r_sel + 1'b1;
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end
        end
    end

    // Staging capture and frame-boundary commit; a load on the commit cycle
    // is written after the commit so it stays pending for the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_digits  <= '0;
            r_stg_dp      <= '0;
            r_disp_digits <= '0;
            r_disp_dp     <= '0;
            r_pending     <= 1'b0;
        end else begin
            if (w_frame && r_pending) begin
                r_disp_digits <= r_stg_digits;
                r_disp_dp     <= r_stg_dp;
                r_pending     <= 1'b0;
            end
            if (load) begin
                r_stg_digits <= digits;
                r_stg_dp     <= dp;
                r_pending    <= 1'b1;
            end
        end
    end

    // Blink half-period counter advanced once per frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame) begin
            if (r_blink_cnt == c_BC_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Select the current digit and compute its suppression flags
    always_comb begin
        w_nibble     = 4'h0;
        w_dp_bit     = 1'b0;
        w_lz_hit     = 1'b0;
        w_blink_hit  = 1'b0;
        w_zero_above = 1'b1;
        w_lz_vec     = '0;
        w_sel_onehot = '0;
        // Walk from the most significant digit down; digit 0 never blanks
        for (int i = NUM_DIG - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above & (r_disp_digits[4*i +: 4] == 4'h0);
            w_lz_vec[i]  = w_zero_above;
        end
        for (int i = 0; i < NUM_DIG; i++) begin
            if (r_sel == c_SEL_W'(i)) begin
                w_nibble        = r_disp_digits[4*i +: 4];
                w_dp_bit        = r_disp_dp[i];
                w_lz_hit        = w_lz_vec[i];
                w_blink_hit     = blink_mask[i];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    // Hex to gfedcba decode, then apply blanking conditions
    always_comb begin
        w_seg_code = 7'h00;
        case (w_nibble)
            4'h0:    w_seg_code = 7'h3F;
            4'h1:    w_seg_code = 7'h06;
            4'h2:    w_seg_code = 7'h5B;
            4'h3:    w_seg_code = 7'h4F;
            4'h4:    w_seg_code = 7'h66;
            4'h5:    w_seg_code = 7'h6D;
            4'h6:    w_seg_code = 7'h7D;
            4'h7:    w_seg_code = 7'h07;
            4'h8:    w_seg_code = 7'h7F;
            4'h9:    w_seg_code = 7'h6F;
            4'hA:    w_seg_code = 7'h77;
            4'hB:    w_seg_code = 7'h7C;
            4'hC:    w_seg_code = 7'h39;
            4'hD:    w_seg_code = 7'h5E;
            4'hE:    w_seg_code = 7'h79;
            4'hF:    w_seg_code = 7'h71;
            default: w_seg_code = 7'h00;
        endcase
        w_seg_on = {w_dp_bit, w_seg_code};
        if ((blank_lz && w_lz_hit) || (w_blink_hit && r_blink_phase) || w_ghost) begin
            w_seg_on = 8'h00;
        end
        w_dig_on = w_ghost ? '0 : w_sel_onehot;
    end

    // Registered outputs with polarity applied here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig <= {NUM_DIG{c_DIG_INV}};
            r_smg <= {8{c_SEG_INV}};
        end else begin
            r_dig <= w_dig_on ^ {NUM_DIG{c_DIG_INV}};
            r_smg <= w_seg_on ^ {8{c_SEG_INV}};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_mux
// Brief    : Self-checking bench for seg_scan_mux (4 digits, 8-cycle slots,
//            2 blank cycles, 2-frame blink half-period, active-low outputs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        load;
    logic        blank_lz;
    logic [3:0]  blink_mask;
    logic [3:0]  dig;
    logic [7:0]  smg;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] cap_dig [1:32];
    logic [7:0] cap_smg [1:32];
    logic       cap_fd  [1:32];

    typedef struct {
        logic             lz;
        logic [15:0]      d;
        logic [3:0]       p;
        logic [3:0][7:0]  e;   // expected smg per slot, e[0] = slot0
    } vec_t;

    vec_t vt [12];

    seg_scan_mux #(
        .NUM_DIG      (4),
        .DIV          (8),
        .BLANK_CYCLES (2),
        .BLINK_FRAMES (2),
        .DIG_ACT_LOW  (1),
        .SEG_ACT_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp         (dp),
        .load       (load),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .dig        (dig),
        .smg        (smg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Active-low expected segment byte for a hex digit and dp bit
    function automatic logic [7:0] seg_exp(input logic [3:0] n, input logic p);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'h3F; 4'h1: c = 7'h06; 4'h2: c = 7'h5B; 4'h3: c = 7'h4F;
            4'h4: c = 7'h66; 4'h5: c = 7'h6D; 4'h6: c = 7'h7D; 4'h7: c = 7'h07;
            4'h8: c = 7'h7F; 4'h9: c = 7'h6F; 4'hA: c = 7'h77; 4'hB: c = 7'h7C;
            4'hC: c = 7'h39; 4'hD: c = 7'h5E; 4'hE: c = 7'h79; default: c = 7'h71;
        endcase
        return ~{p, c};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_fd();
        int w = 0;
        while (frame_done !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (frame_done !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_frame_done: got timeout want pulse");
        end
    endtask

    // Captures the 32 cycles following a frame_done; index m reflects
    // state index m-2 of the new frame (one register stage plus sampling).
    // Optional loads are issued at capture indices la / lb.
    task automatic capture_frame(input int la, input logic [15:0] va,
                                 input int lb, input logic [15:0] vb);
        wait_fd();
        for (int m = 1; m <= 32; m++) begin
            @(negedge clk);
            load       = 1'b0;
            cap_dig[m] = dig;
            cap_smg[m] = smg;
            cap_fd[m]  = frame_done;
            if (m == la) begin digits = va; dp = 4'h0; load = 1'b1; end
            if (m == lb) begin digits = vb; dp = 4'h0; load = 1'b1; end
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        digits = d;
        dp     = p;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Mid-slot check of all four slots against one display word, no dp
    task automatic chk_frame(input string tag, input logic [15:0] d);
        for (int s = 0; s < 4; s++)
            chk($sformatf("%s_slot%0d", tag, s), cap_smg[6 + 8*s], seg_exp(d[4*s +: 4], 1'b0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nfd;
        logic [3:0] exp_dig;

        vt[0]  = '{1'b0, 16'h1234, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vt[1]  = '{1'b1, 16'h0050, 4'b0000, {8'hFF, 8'hFF, 8'h92, 8'hC0}};
        vt[2]  = '{1'b1, 16'h0000, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vt[3]  = '{1'b1, 16'h0050, 4'b0100, {8'hFF, 8'hFF, 8'h92, 8'hC0}};
        vt[4]  = '{1'b0, 16'h0050, 4'b0000, {8'hC0, 8'hC0, 8'h92, 8'hC0}};
        vt[5]  = '{1'b0, 16'h89AB, 4'b0001, {8'h80, 8'h90, 8'h88, 8'h03}};
        vt[6]  = '{1'b0, 16'hCDEF, 4'b1010, {8'h46, 8'hA1, 8'h06, 8'h8E}};
        vt[7]  = '{1'b0, 16'h5670, 4'b0000, {8'h92, 8'h82, 8'hF8, 8'hC0}};
        vt[8]  = '{1'b1, 16'h1000, 4'b0000, {8'hF9, 8'hC0, 8'hC0, 8'hC0}};
        vt[9]  = '{1'b1, 16'h0001, 4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'h79}};
        vt[10] = '{1'b1, 16'h0000, 4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'h40}};
        vt[11] = '{1'b1, 16'h0300, 4'b0010, {8'hFF, 8'hB0, 8'h40, 8'hC0}};

        rst = 1'b1; load = 1'b0; digits = 16'h0; dp = 4'h0;
        blank_lz = 1'b0; blink_mask = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_dig", {4'h0, dig}, 8'h0F);
        chk("rst_smg", smg, 8'hFF);
        chk("rst_fd", {7'h0, frame_done}, 8'h00);

        // Load 1234; display must still show 0 before the first frame_done
        do_load(16'h1234, 4'h0);
        repeat (2) @(negedge clk);
        chk("precommit_dig", {4'h0, dig}, 8'h0E);
        chk("precommit_smg", smg, 8'hC0);

        capture_frame(0, 16'h0, 0, 16'h0);
        chk("f1_slot0_dig", {4'h0, cap_dig[6]}, 8'h0E);
        chk("f1_slot0_smg", cap_smg[6], 8'h99);
        chk("f1_slot3_dig", {4'h0, cap_dig[30]}, 8'h07);
        chk("f1_slot3_smg", cap_smg[30], 8'hF9);

        // Anti-ghost: two blank cycles per slot, then the digit appears
        for (int s = 0; s < 4; s++) begin
            exp_dig = ~(4'b0001 << s);
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("ghost_s%0d_p%0d_dig", s, p), {4'h0, cap_dig[2 + 8*s + p]}, 8'h0F);
                chk($sformatf("ghost_s%0d_p%0d_smg", s, p), cap_smg[2 + 8*s + p], 8'hFF);
            end
            chk($sformatf("visible_s%0d_dig", s), {4'h0, cap_dig[4 + 8*s]}, {4'h0, exp_dig});
            chk($sformatf("visible_s%0d_smg", s), cap_smg[4 + 8*s],
                seg_exp(vt[0].d[4*s +: 4], 1'b0));
        end
        nfd = 0;
        for (int m = 1; m <= 31; m++) nfd += int'(cap_fd[m]);
        chk("fd_none_midframe", 8'(nfd), 8'd0);
        chk("fd_period32", {7'h0, cap_fd[32]}, 8'h01);

        // Table-driven decode / leading-zero / dp vectors
        for (int i = 0; i < 12; i++) begin
            blank_lz = vt[i].lz;
            do_load(vt[i].d, vt[i].p);
            capture_frame(0, 16'h0, 0, 16'h0);
            for (int s = 0; s < 4; s++)
                chk($sformatf("vec%0d_slot%0d", i, s), cap_smg[6 + 8*s], vt[i].e[s]);
        end

        // Tear-free updates
        blank_lz = 1'b0;
        do_load(16'h1234, 4'h0);
        capture_frame(0, 16'h0, 0, 16'h0);
        chk_frame("tf_a", 16'h1234);
        capture_frame(12, 16'h5678, 0, 16'h0);
        chk_frame("tf_b", 16'h1234);
        capture_frame(0, 16'h0, 0, 16'h0);
        chk_frame("tf_c", 16'h5678);
        capture_frame(12, 16'h4321, 32, 16'h2468);
        chk_frame("tf_d", 16'h5678);
        capture_frame(0, 16'h0, 0, 16'h0);
        chk_frame("tf_e", 16'h4321);
        capture_frame(0, 16'h0, 0, 16'h0);
        chk_frame("tf_f", 16'h2468);

        // Blink on slot0: lit, off, off, lit, lit for frames after fd1..fd5
        do_reset();
        blink_mask = 4'b0001;
        do_load(16'h1234, 4'h0);
        for (int f = 1; f <= 5; f++) begin
            capture_frame(0, 16'h0, 0, 16'h0);
            chk($sformatf("blink_f%0d_slot0", f), cap_smg[6],
                (f == 2 || f == 3) ? 8'hFF : 8'h99);
            chk($sformatf("blink_f%0d_slot1", f), cap_smg[14], 8'hB0);
        end
        blink_mask = 4'h0;

        // Reset mid-slot (sel=2, prescaler=5) with a pending load outstanding
        @(negedge clk);
        digits = 16'h1357; dp = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_dig", {4'h0, dig}, 8'h0B);
        chk("pre_rst_smg", smg, 8'hA4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_dig", {4'h0, dig}, 8'h0F);
        chk("midrst_smg", smg, 8'hFF);
        chk("midrst_fd", {7'h0, frame_done}, 8'h00);
        @(negedge clk);
        chk("midrst1_dig", {4'h0, dig}, 8'h0F);
        chk("midrst1_smg", smg, 8'hFF);
        repeat (2) @(negedge clk);
        chk("midrst_disp0_dig", {4'h0, dig}, 8'h0E);
        chk("midrst_disp0_smg", smg, 8'hC0);
        capture_frame(0, 16'h0, 0, 16'h0);
        chk_frame("midrst_nocommit", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
